// File: rtl/display_scan_controller.sv
// display_scan_controller: scans a 4-digit common-anode display with blank/drive slots and a per-frame snapshot
module display_scan_controller #(
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        enable_i,
  input  logic [15:0] value_i,
  input  logic        lz_blank_i,
  input  logic [3:0]  dp_mask_i,
  output logic [2:0]  state_o,
  output logic [3:0]  current_digit_o,
  output logic [3:0]  anode_o,
  output logic        dp_o,
  output logic        frame_start_o
);
  localparam int CW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} fsm_t;
  fsm_t        fsm_q, fsm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d, nidx;
  logic [15:0] snap_q, snap_d;
  logic [2:0]  state_q, state_d;
  logic [3:0]  digit_q, digit_d, anode_q, anode_d, lz_mask;
  logic        dp_q, dp_d, fs_q, fs_d, go_blank;
  // a digit is dark when it and every more significant nibble of the snapshot are zero
  assign lz_mask = {lz_blank_i && snap_q[15:12] == 4'h0, lz_blank_i && snap_q[15:8] == 8'h0,
                    lz_blank_i && snap_q[15:4] == 12'h0, 1'b0};
  assign go_blank = fsm_q == IDLE || (fsm_q == DRIVE && cnt_q == CW'(TICK_DIV - 1));
  assign nidx = fsm_q == IDLE ? 2'd0 : idx_q + 2'd1;
  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    snap_d  = snap_q;
    state_d = 3'd4;
    digit_d = digit_q;
    anode_d = 4'hf;
    dp_d    = 1'b1;
    fs_d    = 1'b0;
    if (!enable_i) begin
      fsm_d   = IDLE;
      cnt_d   = '0;
      idx_d   = 2'd0;
      digit_d = 4'h0;
    end else if (go_blank) begin
      fsm_d  = BLANK;
      cnt_d  = '0;
      idx_d  = nidx;
      snap_d = nidx == 2'd0 ? value_i : snap_q;
      fs_d   = nidx == 2'd0;
      digit_d = snap_d[{nidx, 2'b00} +: 4];
    end else if (fsm_q == DRIVE || cnt_q == CW'(BLANK_CYCLES - 1)) begin
      fsm_d   = DRIVE;
      state_d = {1'b0, idx_q};
      anode_d = lz_mask[idx_q] ? 4'hf : ~(4'b0001 << idx_q);
      dp_d    = lz_mask[idx_q] | ~dp_mask_i[idx_q];
    end
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      snap_q  <= 16'h0000;
      state_q <= 3'd4;
      digit_q <= 4'h0;
      anode_q <= 4'hf;
      dp_q    <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      state_q <= state_d;
      digit_q <= digit_d;
      anode_q <= anode_d;
      dp_q    <= dp_d;
      fs_q    <= fs_d;
    end
  end
  assign state_o         = state_q;
  assign current_digit_o = digit_q;
  assign anode_o         = anode_q;
  assign dp_o            = dp_q;
  assign frame_start_o   = fs_q;
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: frame-position model checked every cycle plus directed literal checks
module tb_display_scan_controller;
  localparam int T = 8;
  localparam int B = 2;
  logic clk = 0, rst_n = 0, en = 0, lz = 0;
  logic [15:0] value = 16'h0;
  logic [3:0] dp = 4'h0;
  logic [2:0] st;
  logic [3:0] cd, an;
  logic dpo, fs;
  int checks = 0, failures = 0;
  display_scan_controller #(.TICK_DIV(T), .BLANK_CYCLES(B)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .enable_i(en), .value_i(value), .lz_blank_i(lz),
    .dp_mask_i(dp), .state_o(st), .current_digit_o(cd), .anode_o(an), .dp_o(dpo),
    .frame_start_o(fs));
  always #5 clk = ~clk;
  // model: position within the frame since enable, in cycles
  logic run;
  int k, kn, slot_n, pos_n;
  logic [15:0] snap, snap_n;
  logic drive_n, blanked_n;
  logic [3:0] onehot_n;
  logic [2:0] e_st;
  logic [3:0] e_cd, e_an;
  logic e_dp, e_fs;
  assign kn = run ? (k + 1) % (4 * T) : 0;
  assign slot_n = (kn / T) % 4;
  assign pos_n = kn % T;
  assign snap_n = kn == 0 ? value : snap;
  assign drive_n = pos_n >= B;
  assign blanked_n = lz && slot_n > 0 && (snap_n >> (4 * slot_n)) == 16'h0;
  assign onehot_n = 4'b0001 << slot_n;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 0; k <= 0; snap <= 16'h0;
      e_st <= 3'd4; e_cd <= 4'h0; e_an <= 4'hf; e_dp <= 1; e_fs <= 0;
    end else if (!en) begin
      run <= 0; k <= 0;
      e_st <= 3'd4; e_cd <= 4'h0; e_an <= 4'hf; e_dp <= 1; e_fs <= 0;
    end else begin
      run <= 1; k <= kn; snap <= snap_n;
      e_st <= drive_n ? 3'(slot_n) : 3'd4;
      e_cd <= 4'((snap_n >> (4 * slot_n)) & 16'hf);
      e_an <= drive_n && !blanked_n ? ~onehot_n : 4'hf;
      e_dp <= drive_n && !blanked_n ? ~dp[slot_n] : 1'b1;
      e_fs <= kn == 0;
    end
  end
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    chk("m_state", 16'(st), 16'(e_st));
    chk("m_digit", 16'(cd), 16'(e_cd));
    chk("m_anode", 16'(an), 16'(e_an));
    chk("m_dp", 16'(dpo), 16'(e_dp));
    chk("m_fs", 16'(fs), 16'(e_fs));
    chk("one_anode", 16'($countones(~an) <= 1), 16'd1);
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  initial begin
    step(3);
    rst_n = 1;
    step(1);
    chk("rst_anode", 16'(an), 16'hf);
    chk("rst_state", 16'(st), 16'd4);
    chk("rst_digit", 16'(cd), 16'h0);
    chk("rst_dp", 16'(dpo), 16'd1);
    chk("rst_fs", 16'(fs), 16'd0);
    en = 1; value = 16'h1234;
    step(1);
    chk("t1_fs", 16'(fs), 16'd1);
    chk("t1_cd0", 16'(cd), 16'h4);
    chk("t1_blank", 16'(an), 16'hf);
    step(2);
    chk("t1_an0", 16'(an), 16'he);
    chk("t1_st0", 16'(st), 16'd0);
    step(6);
    chk("t1_st4", 16'(st), 16'd4);
    chk("t1_cd1", 16'(cd), 16'h3);
    chk("t1_an_blank1", 16'(an), 16'hf);
    chk("t1_fs_low", 16'(fs), 16'd0);
    step(2);
    chk("t1_an1", 16'(an), 16'hd);
    chk("t1_st1", 16'(st), 16'd1);
    step(22);
    chk("t1_fs2", 16'(fs), 16'd1);
    step(10);
    value = 16'h9999;
    step(8);
    chk("t3_cd2", 16'(cd), 16'h2);
    chk("t3_an2", 16'(an), 16'hb);
    step(8);
    chk("t3_cd3", 16'(cd), 16'h1);
    chk("t3_an3", 16'(an), 16'h7);
    step(6);
    chk("t3_fs", 16'(fs), 16'd1);
    chk("t3_cd9", 16'(cd), 16'h9);
    dp = 4'b0100;
    step(17);
    chk("t4_dp_blank2", 16'(dpo), 16'd1);
    step(1);
    chk("t4_dp_drive2", 16'(dpo), 16'd0);
    step(8);
    chk("t4_dp_drive3", 16'(dpo), 16'd1);
    step(6);
    step(19);
    en = 0;
    step(1);
    chk("t5_an_off", 16'(an), 16'hf);
    chk("t5_st_idle", 16'(st), 16'd4);
    step(2);
    en = 1; value = 16'h0005; lz = 1; dp = 4'h0;
    step(1);
    chk("t5_fs", 16'(fs), 16'd1);
    chk("t5_cd_new", 16'(cd), 16'h5);
    step(2);
    chk("t2_an0", 16'(an), 16'he);
    chk("t2_cd0", 16'(cd), 16'h5);
    step(8);
    chk("t2_an1_dark", 16'(an), 16'hf);
    chk("t2_st1", 16'(st), 16'd1);
    step(8);
    chk("t2_an2_dark", 16'(an), 16'hf);
    step(8);
    chk("t2_an3_dark", 16'(an), 16'hf);
    chk("t2_st3", 16'(st), 16'd3);
    step(6);
    lz = 0;
    step(10);
    chk("t2_an1_lit", 16'(an), 16'hd);
    chk("t2_cd1_zero", 16'(cd), 16'h0);
    step(22);
    value = 16'h1234;
    step(10);
    #1 rst_n = 0;
    #1;
    chk("t6_async_an", 16'(an), 16'hf);
    chk("t6_async_st", 16'(st), 16'd4);
    @(posedge clk);
    #2 rst_n = 1;
    step(1);
    chk("t6_fs", 16'(fs), 16'd1);
    chk("t6_cd", 16'(cd), 16'h4);
    step(2);
    chk("t6_an0", 16'(an), 16'he);
    step(40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
